// File: rtl/dec_timer16_if.sv
// dec_timer16_if: bus bundle for the dec_timer16 down-counter.
//   master : drives in/load/dec/reload_en and observes out/zero/done/uflow
//   slave  : the timer itself
// Signals:
//   in        load value for the counter and the reload register
//   load      capture in into out and reload
//   dec       decrement enable
//   reload_en auto-reload (1) or wrap to all-ones (0) at underflow
//   out       current count (registered)
//   zero      out == 0 (combinational)
//   done      one-cycle pulse, count reached zero by a decrement
//   uflow     one-cycle pulse, decrement taken while out == 0
interface dec_timer16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             dec;
    logic             reload_en;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             done;
    logic             uflow;

    modport master (
        output in, load, dec, reload_en,
        input  out, zero, done, uflow
    );

    modport slave (
        input  in, load, dec, reload_en,
        output out, zero, done, uflow
    );
endinterface

// File: rtl/dec_timer16.sv
// dec_timer16: loadable down-counter with auto-reload or wrap at underflow.
// Ports:
//   clock  single clock, rising-edge
//   reset  synchronous active-high reset
//   bus    dec_timer16_if.slave (in/load/dec/reload_en in, out/zero/done/uflow out)
// Edge priority: reset > load > dec > hold.
module dec_timer16 #(
    parameter int WIDTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    dec_timer16_if.slave   bus
);
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             uflow_q, uflow_d;

    always_comb begin
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        uflow_d  = 1'b0;
        if (bus.load) begin
            out_d    = bus.in;
            reload_d = bus.in;
        end else if (bus.dec) begin
            if (out_q != '0) begin
                out_d  = out_q - WIDTH'(1);
                done_d = (out_q == WIDTH'(1));
            end else begin
                // reload_en only matters here, at the underflow itself
                uflow_d = 1'b1;
                if (bus.reload_en) begin
                    out_d  = reload_q;
                    done_d = (reload_q == '0);
                end else begin
                    out_d  = '1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            uflow_q  <= uflow_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.zero  = (out_q == '0);
    assign bus.done  = done_q;
    assign bus.uflow = uflow_q;
endmodule

// File: tb/tb_dec_timer16.sv
module tb_dec_timer16;
    localparam int W   = 16;
    localparam int MOD = 1 << W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dec_timer16_if #(.WIDTH(W)) bus ();

    dec_timer16 #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural reference: plain integer arithmetic modulo 2^W
    int m_out    = 0;
    int m_reload = 0;
    int m_done   = 0;
    int m_uflow  = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] din;
        logic        dec;
        logic        re;
        logic [15:0] e_out;
        logic        e_done;
        logic        e_uf;
        logic        e_zero;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic ld, logic [15:0] din, logic dec, logic re,
                               logic [15:0] e_out, logic e_done, logic e_uf, logic e_zero);
        vec_t t;
        t.rst = rst; t.ld = ld; t.din = din; t.dec = dec; t.re = re;
        t.e_out = e_out; t.e_done = e_done; t.e_uf = e_uf; t.e_zero = e_zero;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs, clock it, advance the model, sample #1 after the edge
    task automatic step(input logic rst, input logic ld, input logic [15:0] din,
                        input logic dec, input logic re);
        int new_out;
        reset         = rst;
        bus.load      = ld;
        bus.in        = din;
        bus.dec       = dec;
        bus.reload_en = re;
        @(posedge clock);
        if (rst) begin
            m_out = 0; m_reload = 0; m_done = 0; m_uflow = 0;
        end else if (ld) begin
            m_out = int'(din); m_reload = int'(din); m_done = 0; m_uflow = 0;
        end else if (dec) begin
            m_uflow = (m_out == 0) ? 1 : 0;
            if (m_out == 0 && re) new_out = m_reload;
            else                  new_out = (m_out + MOD - 1) % MOD;
            m_out  = new_out;
            m_done = (new_out == 0) ? 1 : 0;
        end else begin
            m_done = 0; m_uflow = 0;
        end
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out,
                             input logic e_done, input logic e_uf, input logic e_zero);
        check({tag, " out"},   32'(bus.out),   32'(e_out));
        check({tag, " done"},  32'(bus.done),  32'(e_done));
        check({tag, " uflow"}, 32'(bus.uflow), 32'(e_uf));
        check({tag, " zero"},  32'(bus.zero),  32'(e_zero));
    endtask

    initial begin
        bus.load = 1'b0; bus.in = '0; bus.dec = 1'b0; bus.reload_en = 1'b0;

        // rst ld din dec re | out done uflow zero
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        // count 5 down to 0
        tbl.push_back(v(0, 1, 16'h0005, 0, 0, 16'h0005, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0004, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0003, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0002, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0001, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        // load 0, wrap to all-ones
        tbl.push_back(v(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 1, 0));
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 0));
        // auto-reload from 3
        tbl.push_back(v(0, 1, 16'h0003, 0, 1, 16'h0003, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0002, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0003, 0, 1, 0));
        tbl.push_back(v(0, 0, 16'h0000, 0, 1, 16'h0003, 0, 0, 0));
        // load beats dec
        tbl.push_back(v(0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0, 0));
        tbl.push_back(v(0, 1, 16'hFFFB, 1, 0, 16'hFFFB, 0, 0, 0));
        // reset beats load and dec mid-count
        tbl.push_back(v(0, 1, 16'h0010, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h000F, 0, 0, 0));
        tbl.push_back(v(1, 1, 16'h1234, 1, 0, 16'h0000, 0, 0, 1));
        // hold at all-ones
        tbl.push_back(v(0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 0));
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 0));
        // reload register cleared by reset: reload of 0 gives done+uflow, every cycle
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 1, 1));
        tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 1, 1));
        tbl.push_back(v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].din, tbl[i].dec, tbl[i].re);
            check_all($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_done, tbl[i].e_uf, tbl[i].e_zero);
        end

        // reload_en toggling away from the underflow cycle has no effect
        step(0, 1, 16'h0002, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        check_all("seqA at0", 16'h0000, 1, 0, 1);
        step(0, 0, 16'h0000, 1, 0);
        check_all("seqA wrap", 16'hFFFF, 0, 1, 0);

        step(0, 1, 16'h0001, 0, 0);
        step(0, 0, 16'h0000, 1, 0);
        check_all("seqB at0", 16'h0000, 1, 0, 1);
        step(0, 0, 16'h0000, 0, 0);
        check_all("seqB hold", 16'h0000, 0, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        check_all("seqB reload", 16'h0001, 0, 1, 0);
        step(0, 0, 16'h0000, 1, 0);
        check_all("seqB again", 16'h0000, 1, 0, 1);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_ld, r_dec, r_re;
            logic [15:0] r_in;
            r_rst = ($urandom_range(0, 59) == 0);
            r_ld  = ($urandom_range(0, 5) == 0);
            r_dec = ($urandom_range(0, 3) != 0);
            r_re  = $urandom_range(0, 1) == 1;
            r_in  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 4)) : 16'($urandom);
            step(r_rst, r_ld, r_in, r_dec, r_re);
            check_all($sformatf("rnd%0d", i), 16'(m_out), m_done[0], m_uflow[0], (m_out == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dec_timer16.md
DEC_TIMER16 -- requirements
Module: dec_timer16

Interface
REQ-001 Parameter WIDTH, default 16, counter and data width in bits; all widths below refer to WIDTH.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 in  input  WIDTH  load value for counter and reload register.
REQ-005 load  input  1  when high, in is captured into out and into reload register.
REQ-006 dec  input  1  decrement enable.
REQ-007 reload_en  input  1  selects auto-reload (1) or two's-complement wrap (0) at underflow.
REQ-008 out  output  WIDTH  current count, registered.
REQ-009 zero  output  1  combinational, high when out == 0.
REQ-010 done  output  1  registered one-cycle pulse marking count reaching zero by decrement.
REQ-011 uflow  output  1  registered one-cycle pulse marking decrement taken while out == 0.

Function
REQ-012 Priority per edge SHALL be reset > load > dec > hold.
REQ-013 load=1: out <= in, reload <= in, done <= 0, uflow <= 0, regardless of dec.
REQ-014 dec=1, load=0, out != 0: out <= out - 1; done <= 1 iff out == 1, else 0; uflow <= 0.
REQ-015 dec=1, load=0, out == 0, reload_en=0: out <= all-ones (0xFFFF at WIDTH=16); uflow <= 1; done <= 0.
REQ-016 dec=1, load=0, out == 0, reload_en=1: out <= reload; uflow <= 1; done <= 1 iff reload == 0, else 0.
REQ-017 dec=0, load=0: out and reload hold; done <= 0; uflow <= 0.
REQ-018 Arithmetic modulo 2^WIDTH; no saturation; decrement latency one clock.
REQ-019 done and uflow SHALL never stay high longer than one cycle unless the triggering condition recurs every cycle.
REQ-020 zero SHALL track out in the same cycle, with no added latency.
REQ-021 reload_en SHALL be sampled only in the cycle where underflow occurs; changes at other times have no effect.
REQ-022 load of 0 SHALL set out=0, zero=1, done=0; a following dec is an underflow per REQ-015/016.

Reset
REQ-023 reset=1 at a clock edge: out <= 0, reload <= 0, done <= 0, uflow <= 0; zero reads 1 after reset.
REQ-024 reset asserted mid-count SHALL override simultaneous load and dec in that cycle.
REQ-025 No output SHALL be X after the first reset edge.

Verification
REQ-026 reset, load in=0x0005, then 5 cycles dec=1 -> out 4,3,2,1,0; done high only in the cycle out becomes 0; zero=1 at end.
REQ-027 load in=0x0000, reload_en=0, dec one cycle -> out=0xFFFF, uflow=1 for one cycle, done=0.
REQ-028 load in=0x0003, reload_en=1, dec 4 cycles -> out 2,1,0,3; done pulse at 0; uflow pulse at 3.
REQ-029 out=0x0002, load=1 in=0xFFFB together with dec=1 -> out=0xFFFB (load wins), done=0, uflow=0.
REQ-030 counting from 0x0010 with dec=1, reset=1 with load=1 in=0x1234 -> out=0x0000, done=0, uflow=0, zero=1.
REQ-031 load in=0xFFFF, dec=0 for 3 cycles -> out holds 0xFFFF, zero=0, done=0, uflow=0.
